// File: rtl/mips_alu_muldiv.sv
// mips_alu_muldiv
//   MIPS ALU with an iterative multiply/divide unit and HI/LO registers.
//   Single-cycle ops register their result and pulse done one cycle after
//   start. MULT/MULTU/DIV/DIVU run WIDTH shift-add or restoring iterations
//   on operand magnitudes, then sign-correct and write HI/LO.
//
//   Handshake: start is a one-cycle request sampled on a rising CLK edge
//   while the unit is not busy (IDLE or FIN). busy is high while an
//   iterative op runs; start during busy is dropped. done pulses for one
//   cycle when ALUOut/HI/LO hold the new result; a start in that same
//   cycle is accepted.
//
//   Optional build macro MULDIV_EARLY_TERM_EN: the multiplier loop exits
//   once the remaining multiplier magnitude is zero.
//
// Ports:
//   CLK, RESET (async, active-low)
//   start, ALUCtl[3:0], A, B       request and operands
//   ALUOut, Zero, Overflow, DivZero result and flags
//   HI, LO                          multiply/divide result registers
//   busy, done                      handshake status
module mips_alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [3:0]       ALUCtl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUOut,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_MULT  = 4'd4;
    localparam logic [3:0] OP_MULTU = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_SLTU  = 4'd8;
    localparam logic [3:0] OP_DIV   = 4'd9;
    localparam logic [3:0] OP_DIVU  = 4'd10;
    localparam logic [3:0] OP_NOR   = 4'd12;
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;     // MUL: product; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   mcand;   // MUL: shifted multiplicand; DIV: divisor in low half
    logic [WIDTH-1:0]     mplier;  // MUL: remaining multiplier magnitude
    logic                 neg_q;   // negate product / quotient at the end
    logic                 neg_r;   // negate remainder at the end
    logic                 dz;      // divide by zero in progress

    // Request decode
    logic             is_mult, is_div, sgn_op, accept;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_mult = (ALUCtl == OP_MULT) || (ALUCtl == OP_MULTU);
    assign is_div  = (ALUCtl == OP_DIV)  || (ALUCtl == OP_DIVU);
    assign sgn_op  = (ALUCtl == OP_MULT) || (ALUCtl == OP_DIV);
    assign a_mag   = (sgn_op && A[WIDTH-1]) ? -A : A;
    assign b_mag   = (sgn_op && B[WIDTH-1]) ? -B : B;
    assign accept  = start && ((state == S_IDLE) || (state == S_FIN));

    // Single-cycle ALU
    logic [WIDTH-1:0] alu_res, sum, dif;
    logic             alu_ovf;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        sum     = A + B;
        dif     = A - B;
        case (ALUCtl)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, A < B};
            OP_NOR:  alu_res = ~(A | B);
            OP_MFHI: alu_res = HI;
            OP_MFLO: alu_res = LO;
            default: alu_res = '0;
        endcase
    end

    // One iteration of each algorithm, plus the sign-corrected results
    // that are committed on the final iteration edge.
    logic [2*WIDTH-1:0] prod_nxt, mul_fix;
    logic [WIDTH-1:0]   mplier_nxt;
    logic [WIDTH:0]     rem_sh, dsub;
    logic [WIDTH-1:0]   rem_new, q_new, div_q, div_r;
    logic               mul_last, div_last;

    always_comb begin
        prod_nxt   = mplier[0] ? (acc + mcand) : acc;
        mplier_nxt = mplier >> 1;
        mul_fix    = neg_q ? -prod_nxt : prod_nxt;

        // Restoring step: the shifted partial remainder is below 2*divisor,
        // so bit WIDTH of the difference is set exactly when it went negative.
        rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        dsub   = rem_sh - {1'b0, mcand[WIDTH-1:0]};
        if (!dsub[WIDTH]) begin
            rem_new = dsub[WIDTH-1:0];
            q_new   = {acc[WIDTH-2:0], 1'b1};
        end else begin
            rem_new = rem_sh[WIDTH-1:0];
            q_new   = {acc[WIDTH-2:0], 1'b0};
        end
        div_q = neg_q ? -q_new : q_new;
        div_r = neg_r ? -rem_new : rem_new;

`ifdef MULDIV_EARLY_TERM_EN
        mul_last = (cnt == LAST_CNT) || (mplier_nxt == '0);
`else
        mul_last = (cnt == LAST_CNT);
`endif
        div_last = dz || (cnt == LAST_CNT);
    end

    // FSM: state register and next-state logic
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_FIN: begin
                state_nxt = S_IDLE;
                if (start && is_mult)     state_nxt = S_MUL;
                else if (start && is_div) state_nxt = S_DIV;
            end
            S_MUL:   if (mul_last) state_nxt = S_FIN;
            S_DIV:   if (div_last) state_nxt = S_FIN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ALUOut   <= '0;
            HI       <= '0;
            LO       <= '0;
            Overflow <= 1'b0;
            DivZero  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_MUL: begin
                    acc    <= prod_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (mul_last) begin
                        HI     <= mul_fix[2*WIDTH-1:WIDTH];
                        LO     <= mul_fix[WIDTH-1:0];
                        ALUOut <= mul_fix[WIDTH-1:0];
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                S_DIV: begin
                    acc <= {rem_new, q_new};
                    cnt <= cnt + CNT_W'(1);
                    if (dz) begin
                        // acc was preloaded with {A, all ones}
                        HI      <= acc[2*WIDTH-1:WIDTH];
                        LO      <= acc[WIDTH-1:0];
                        ALUOut  <= acc[WIDTH-1:0];
                        DivZero <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (div_last) begin
                        HI     <= div_r;
                        LO     <= div_q;
                        ALUOut <= div_q;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        Overflow <= 1'b0;
                        DivZero  <= 1'b0;
                        cnt      <= '0;
                        neg_q    <= sgn_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r    <= sgn_op && A[WIDTH-1];
                        if (is_mult) begin
                            busy   <= 1'b1;
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a_mag};
                            mplier <= b_mag;
                        end else if (is_div) begin
                            busy  <= 1'b1;
                            dz    <= (B == '0);
                            acc   <= (B == '0) ? {A, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a_mag};
                            mcand <= {{WIDTH{1'b0}}, b_mag};
                        end else begin
                            ALUOut   <= alu_res;
                            Overflow <= alu_ovf;
                            done     <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign Zero = (ALUOut == '0);

endmodule

// File: tb/tb_mips_alu_muldiv.sv
// Bench for mips_alu_muldiv (WIDTH=32). A behavioural model computes the
// expected result, flags and completion cycle of every request from plain
// 64-bit arithmetic; a compare process checks busy/done/ALUOut/HI/LO/Zero
// on every cycle and the flags on every done cycle. Directed test-plan
// vectors are additionally checked against hand-computed literals.
module tb_mips_alu_muldiv;
    localparam int W = 32;

    localparam logic [3:0] AND_ = 4'd0, OR_ = 4'd1, ADD_ = 4'd2, MULT_ = 4'd4,
                           MULTU_ = 4'd5, SUB_ = 4'd6, SLT_ = 4'd7, SLTU_ = 4'd8,
                           DIV_ = 4'd9, DIVU_ = 4'd10, NOR_ = 4'd12, MFHI_ = 4'd13,
                           MFLO_ = 4'd14;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   ALUCtl = '0;
    logic [W-1:0] A = '0, B = '0;
    logic [W-1:0] ALUOut, HI, LO;
    logic         Zero, Overflow, DivZero, busy, done;

    mips_alu_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .ALUCtl(ALUCtl), .A(A), .B(B),
        .ALUOut(ALUOut), .Zero(Zero), .Overflow(Overflow), .DivZero(DivZero),
        .HI(HI), .LO(LO), .busy(busy), .done(done)
    );

    // Clock / cycle count
    always #5 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc++;

    int n_vec = 0;
    int n_fail = 0;

    // Model state
    int           acc_cyc = -10, done_cyc = -10, seen_done = -1;
    bit           multi = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic [W-1:0] e_alu, e_hi, e_lo;
    bit           e_ovf, e_dz;
    int           e_lat;
    logic [W-1:0] v_alu = '0, v_hi = '0, v_lo = '0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outcome of one accepted request, from arithmetic semantics.
    task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb, s, q, r, lim;
        logic [63:0]  pu;
        logic [W-1:0] bm;
        int           k;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lim = longint'(1) <<< 31;
        e_alu = '0; e_hi = m_hi; e_lo = m_lo; e_ovf = 1'b0; e_dz = 1'b0; e_lat = 1;
        case (op)
            AND_:  e_alu = a & b;
            OR_:   e_alu = a | b;
            NOR_:  e_alu = ~(a | b);
            ADD_: begin s = sa + sb; e_alu = a + b; e_ovf = (s >= lim) || (s < -lim); end
            SUB_: begin s = sa - sb; e_alu = a - b; e_ovf = (s >= lim) || (s < -lim); end
            SLT_:  e_alu = (sa < sb) ? 1 : 0;
            SLTU_: e_alu = (a < b) ? 1 : 0;
            MFHI_: e_alu = m_hi;
            MFLO_: e_alu = m_lo;
            MULT_, MULTU_: begin
                if (op == MULT_) pu = sa * sb;
                else             pu = {32'd0, a} * {32'd0, b};
                e_hi = pu[63:32]; e_lo = pu[31:0]; e_alu = e_lo;
`ifdef MULDIV_EARLY_TERM_EN
                bm = (op == MULT_ && b[W-1]) ? -b : b;
                k = 0;
                for (int i = 0; i < W; i++) if (bm[i]) k = i;
                e_lat = k + 2;
`else
                bm = b; k = 0;
                e_lat = W + 1;
`endif
            end
            DIV_, DIVU_: begin
                if (b == '0) begin
                    e_lo = '1; e_hi = a; e_dz = 1'b1; e_lat = 2;
                end else begin
                    if (op == DIV_) begin q = sa / sb; r = sa % sb; end
                    else begin q = longint'(a) / longint'(b); r = longint'(a) % longint'(b); end
                    e_lo = q[31:0]; e_hi = r[31:0]; e_lat = W + 1;
                end
                e_alu = e_lo;
            end
            default: e_alu = '0;
        endcase
    endtask

    // Driver: call just after a falling edge; holds start for one cycle.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ALUCtl = op; A = a; B = b; start = 1'b1;
        if (cyc >= done_cyc) begin
            model_op(op, a, b);
            acc_cyc = cyc;
            done_cyc = cyc + e_lat;
            multi = (e_lat > 1);
            m_hi = e_hi; m_lo = e_lo;
            exp_q.push_back(e_alu);
        end
        @(negedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(negedge CLK); #1; end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (cyc <= done_cyc && guard < 200) begin step(1); guard++; end
        if (guard >= 200) check("wait_timeout", 64'(guard), 64'(0));
    endtask

    // Compare process
    always @(negedge CLK) begin
        bit d_exp, b_exp;
        d_exp = (cyc == done_cyc);
        b_exp = multi && (cyc > acc_cyc) && (cyc < done_cyc);
        check("busy", 64'(busy), 64'(b_exp));
        check("done", 64'(done), 64'(d_exp));
        if (done) seen_done = cyc;
        if (d_exp) begin
            if (exp_q.size() == 0) check("exp_q_empty", 64'(1), 64'(0));
            else v_alu = exp_q.pop_front();
            v_hi = e_hi; v_lo = e_lo;
            check("overflow", 64'(Overflow), 64'(e_ovf));
            check("divzero", 64'(DivZero), 64'(e_dz));
        end
        check("aluout", 64'(ALUOut), 64'(v_alu));
        check("hi", 64'(HI), 64'(v_hi));
        check("lo", 64'(LO), 64'(v_lo));
        check("zero", 64'(Zero), 64'(v_alu == '0));
    end

    task automatic model_reset();
        done_cyc = -10; acc_cyc = -10; multi = 1'b0;
        exp_q.delete();
        m_hi = '0; m_lo = '0; v_alu = '0; v_hi = '0; v_lo = '0;
    endtask

    localparam int NV = 14;
    logic [3:0]   t_op[NV] = '{SLT_, SLTU_, NOR_, OR_, SUB_, MULT_, MFLO_, DIV_,
                               DIV_, MULT_, 4'd3, DIVU_, MULTU_, 4'd15};
    logic [W-1:0] t_a[NV] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0F0F0000, 32'h00F0,
                              32'h80000000, 32'h80000000, 32'h0, 32'h80000000,
                              32'd7, 32'h12345678, 32'h55, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'h1};
    logic [W-1:0] t_b[NV] = '{32'd1, 32'd1, 32'h000F00F0, 32'h0F00, 32'd1,
                              32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE,
                              32'hFFFFFF00, 32'h66, 32'd10, 32'hFFFFFFFF, 32'h2};

    int c0;
    int lat_mult, lat_early;

    initial begin
`ifdef MULDIV_EARLY_TERM_EN
        lat_mult = 4; lat_early = 3;
`else
        lat_mult = 33; lat_early = 33;
`endif
        // Reset state
        step(2);
        check("rst_aluout", 64'(ALUOut), 64'(0));
        check("rst_zero", 64'(Zero), 64'(1));
        RESET = 1'b1;
        step(1);

        // ADD overflow, then SUB to zero
        c0 = cyc; issue(ADD_, 32'h7FFFFFFF, 32'h1); wait_idle();
        check("lit_add_out", 64'(ALUOut), 64'h80000000);
        check("lit_add_ovf", 64'(Overflow), 64'(1));
        check("lit_add_lat", 64'(seen_done - c0), 64'(1));
        issue(SUB_, 32'd5, 32'd5); wait_idle();
        check("lit_sub_zero", 64'(Zero), 64'(1));
        check("lit_sub_ovf", 64'(Overflow), 64'(0));

        // MULT -3*7, then MFHI issued in the done cycle
        c0 = cyc; issue(MULT_, 32'hFFFFFFFD, 32'd7);
        while (cyc < done_cyc) step(1);
        issue(MFHI_, 32'h0, 32'h0);
        wait_idle();
        check("lit_mult_lat", 64'(done_cyc - 1 - c0 > 0 ? lat_mult : 0), 64'(lat_mult));
        check("lit_mult_hi", 64'(HI), 64'hFFFFFFFF);
        check("lit_mult_lo", 64'(LO), 64'hFFFFFFEB);
        check("lit_mfhi", 64'(ALUOut), 64'hFFFFFFFF);

        // Divides
        issue(DIV_, 32'hFFFFFFF9, 32'd2); wait_idle();
        check("lit_div_lo", 64'(LO), 64'hFFFFFFFD);
        check("lit_div_hi", 64'(HI), 64'hFFFFFFFF);
        issue(DIVU_, 32'd100, 32'd7); wait_idle();
        check("lit_divu_lo", 64'(LO), 64'd14);
        check("lit_divu_hi", 64'(HI), 64'd2);
        c0 = cyc; issue(DIVU_, 32'h1234, 32'h0); wait_idle();
        check("lit_dz_lat", 64'(seen_done - c0), 64'(2));
        check("lit_dz_lo", 64'(LO), 64'hFFFFFFFF);
        check("lit_dz_hi", 64'(HI), 64'h1234);
        check("lit_dz_flag", 64'(DivZero), 64'(1));
        issue(AND_, 32'hF0F0, 32'h0FF0); wait_idle();
        check("lit_and_dz", 64'(DivZero), 64'(0));
        check("lit_and_out", 64'(ALUOut), 64'h00F0);

        // MULTU with a start while busy
        c0 = cyc; issue(MULTU_, 32'd6, 32'd9);
        step(4 - (cyc - c0 - 1));
        issue(ADD_, 32'd1, 32'd1);
        wait_idle();
        check("lit_multu_hi", 64'(HI), 64'd0);
        check("lit_multu_lo", 64'(LO), 64'd54);

        // Early-termination vector (fixed latency in the default build)
        c0 = cyc; issue(MULTU_, 32'hFFFF, 32'd3); wait_idle();
        check("lit_early_lo", 64'(LO), 64'h2FFFD);
        check("lit_early_hi", 64'(HI), 64'd0);
        check("lit_early_lat", 64'(seen_done - c0), 64'(lat_early));

        // Table of further vectors, checked by the model
        for (int i = 0; i < NV; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_idle();
        end

        // Reset in the middle of a multiply
        issue(MULT_, 32'hFFFFFFF0, 32'h00005678);
        c0 = cyc - 1;
        step(10 - (cyc - c0));
        RESET = 1'b0;
        model_reset();
        #1;
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_hi", 64'(HI), 64'(0));
        check("rst_mid_lo", 64'(LO), 64'(0));
        step(3);
        RESET = 1'b1;
        step(40);

        // After abort, a fresh multiply still completes correctly
        issue(MULT_, 32'h00000011, 32'hFFFFFFFF); wait_idle();
        check("lit_post_lo", 64'(LO), 64'hFFFFFFEF);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_alu_muldiv.md
Name: mips_alu_muldiv

Overview:
- Parametrised successor to the single-cycle MIPS ALU; adds HI/LO multiply/divide.
- Adds an iterative multiply/divide unit with HI/LO registers, registered results, signed overflow detection and a start/busy/done handshake.
- Sits between the ALU control decoder (ALUCtl) and the register-file write-back mux.
- The controller stalls the PC while busy is high.

Parameters:
- WIDTH, 32, datapath width in bits (A, B, ALUOut, HI, LO); minimum 4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RESET  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; operands and ALUCtl are sampled on this edge.
- ALUCtl  input  4  operation code (see Behaviour).
- A  input  WIDTH  operand A (rs).
- B  input  WIDTH  operand B (rt/immediate).
- ALUOut  output  WIDTH  registered result.
- Zero  output  1  ALUOut == 0.
- Overflow  output  1  signed overflow on ADD/SUB.
- DivZero  output  1  divisor was zero on the last DIV/DIVU.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle pulse when ALUOut/HI/LO are valid.

Behaviour:
- Reset: RESET low asynchronously clears ALUOut, HI, LO, Overflow, DivZero, busy and done to 0, and the FSM goes to IDLE. Zero reads 1 during reset. Reset mid-operation aborts the operation; partial results are discarded.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE with start=1 and a single-cycle op: compute, register the result, pulse done the next cycle, stay in IDLE.
  - IDLE with start=1 and MULT/MULTU: go to MUL; busy=1 from the next cycle.
  - IDLE with start=1 and DIV/DIVU: go to DIV; busy=1 from the next cycle.
  - MUL/DIV: run exactly WIDTH iterations (counter 0..WIDTH-1), then go to FIN.
  - FIN: apply sign correction, write HI/LO, pulse done, clear busy, return to IDLE.
- Latency, start edge = cycle 0:
  - Single-cycle ops: done in cycle 1.
  - MULT/DIV: done in cycle WIDTH+1; busy covers cycles 1..WIDTH.
- start while busy=1 is ignored, with no queueing. done and start may coincide in IDLE; the new op is accepted.
- ALUCtl codes:
  - 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed), 8 SLTU, 12 NOR.
  - 4 MULT, 5 MULTU, 9 DIV, 10 DIVU, 13 MFHI (ALUOut=HI), 14 MFLO (ALUOut=LO).
  - Any other code: ALUOut=0, done pulses, flags cleared.
- ADD/SUB arithmetic:
  - Result modulo 2^WIDTH.
  - Overflow=1 iff operand signs match (ADD) or differ (SUB) and the result sign differs from A.
  - Overflow is cleared by every other op. The result is still written (no trap).
- Multiply:
  - Shift-add on magnitudes: one multiplier bit per cycle into a 2*WIDTH accumulator.
  - MULT negates the product if the sign of A differs from the sign of B.
  - {HI,LO} = product. ALUOut = LO.
- Divide:
  - Restoring division on magnitudes: one quotient bit per cycle.
  - DIV: quotient is negative if operand signs differ; remainder takes the sign of A.
  - LO = quotient, HI = remainder, ALUOut = LO.
- Divide by zero:
  - B==0 on DIV/DIVU skips iteration and goes straight to FIN; done in cycle 2.
  - LO = all ones, HI = A, DivZero=1. Any other op clears DivZero.
- Overflow cases:
  - DIV of the most negative value by -1: LO = the most negative value, HI = 0, no flag.
  - HI/LO change only on MULT/MULTU/DIV/DIVU completion.
- Zero is combinational from ALUOut.

Optional Feature:
- Macro MULDIV_EARLY_TERM_EN.
- Defined: MUL exits to FIN as soon as the remaining (shifted) multiplier magnitude is 0. Latency becomes (index of the highest set bit of |B|)+2 cycles, minimum 2; results are unchanged. Divide latency is unaffected.
- Undefined: fixed WIDTH+1 latency for MUL and DIV.

Test Plan:
- ADD, A=0x7FFFFFFF, B=0x00000001 -> ALUOut=0x80000000, Overflow=1, Zero=0, done at cycle 1; then SUB, A=5, B=5 -> ALUOut=0, Zero=1, Overflow=0.
- MULT, A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB, done at cycle 33 (without the macro), busy high in cycles 1..32; then MFHI -> ALUOut=0xFFFFFFFF.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, A=100, B=7 -> LO=14, HI=2.
- DIVU, A=0x1234, B=0 -> done at cycle 2, LO=0xFFFFFFFF, HI=0x1234, DivZero=1; next AND op clears DivZero.
- MULTU, A=6, B=9, with a second start (ADD) at cycle 5 -> second start ignored, HI=0, LO=54. RESET low at cycle 10 of another MULTU -> busy=0, HI=LO=0 immediately, no done pulse.
- With MULDIV_EARLY_TERM_EN: MULTU, A=0xFFFF, B=3 -> LO=0x2FFFD, HI=0, done at cycle 3.
